// File: rtl/wb_daq_sample_packer_pkg.sv
// Shared widths, channel count and helpers for the DAQ sample packer.
package wb_daq_sample_packer_pkg;

    // Default bus and ADC widths, and the number of DAQ channels in the system.
    localparam int unsigned DAQ_DW           = 32;
    localparam int unsigned DAQ_ADC_DW       = 8;
    localparam int unsigned DAQ_NUM_CHANNELS = 4;

    // Number of ADC samples packed into one bus word.
    function automatic int unsigned daq_lanes(input int unsigned dw, input int unsigned adc_dw);
        return dw / adc_dw;
    endfunction

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Why a word is being pushed into the FIFO this cycle.
    typedef enum logic [1:0] {
        PushNone,
        PushWord,
        PushFlush
    } push_src_e;

endpackage

// File: rtl/wb_daq_sync_fifo.sv
// Single-clock show-ahead FIFO. The head word is visible on head_o whenever the FIFO is
// non-empty and reads as zero when empty. A push while full only succeeds together with a pop.
module wb_daq_sync_fifo
    import wb_daq_sample_packer_pkg::*;
#(
    parameter int unsigned dw    = DAQ_DW,
    parameter int unsigned depth = 8      // power of two, at least 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [dw-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [dw-1:0]            head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(depth):0]   count_o
);

    localparam int unsigned PtrW = idx_width(depth);
    localparam int unsigned CntW = $clog2(depth) + 1;

    logic [dw-1:0]   mem_q [depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_en;
    logic            pop_en;

    // Qualify push/pop against occupancy and compute next pointers and count.
    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CntW'(depth));
        pop_en   = pop_i & ~empty_o;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push_en  = push_i & (~full_o | pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally since depth is a power of two.
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, guarded by count.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Show-ahead head, forced to zero while empty so stale data never appears on the bus.
    always_comb begin
        head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
        count_o = count_q;
    end

endmodule

// File: rtl/wb_daq_sample_packer.sv
// Per-channel packer: gathers ADC samples little-endian into bus words, flushes a
// zero-padded partial word when the channel is disabled, and queues words for the
// bus master in a show-ahead FIFO. A sticky flag records any word dropped on overflow.
module wb_daq_sample_packer
    import wb_daq_sample_packer_pkg::*;
#(
    parameter int unsigned dw         = DAQ_DW,
    parameter int unsigned adc_dw     = DAQ_ADC_DW,
    parameter int unsigned fifo_depth = 8
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst,
    input  logic                          enable,
    input  logic                          sample_valid,
    input  logic [adc_dw-1:0]             sample_data,
    input  logic                          word_ack,
    output logic [dw-1:0]                 data_out,
    output logic                          start_sram,
    output logic [$clog2(fifo_depth):0]   fill_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int unsigned Lanes    = daq_lanes(dw, adc_dw);
    localparam int unsigned LaneW    = idx_width(Lanes);
    localparam logic [LaneW-1:0] LastLane = LaneW'(Lanes - 1);

    logic [LaneW-1:0] lane_q, lane_d;
    logic [dw-1:0]    partial_q, partial_d;
    logic             overflow_q, overflow_d;
    logic [dw-1:0]    merged;
    logic [dw-1:0]    push_word;
    push_src_e        push_src;
    logic             push_req;
    logic             accept;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;

    // Lane packing, word completion and disable-time flush of a partial word.
    always_comb begin
        accept    = sample_valid & enable;
        merged    = partial_q;
        lane_d    = lane_q;
        partial_d = partial_q;
        push_word = '0;
        push_src  = PushNone;
        for (int unsigned l = 0; l < Lanes; l++) begin
            if (lane_q == LaneW'(l)) begin
                merged[l*adc_dw +: adc_dw] = sample_data;
            end
        end
        if (accept) begin
            if (lane_q == LastLane) begin
                push_src  = PushWord;
                push_word = merged;
                partial_d = '0;
                lane_d    = '0;
            end else begin
                partial_d = merged;
                lane_d    = lane_q + LaneW'(1);
            end
        end else if (!enable && lane_q != '0) begin
            // Unused upper lanes are already zero, so the partial word is pushed as-is.
            push_src  = PushFlush;
            push_word = partial_q;
            partial_d = '0;
            lane_d    = '0;
        end
        push_req = (push_src != PushNone);
    end

    // Sticky overflow: a push into a full FIFO with no simultaneous ack is dropped.
    // Setting takes priority over a clear in the same cycle.
    always_comb begin
        drop       = push_req & fifo_full & ~word_ack;
        overflow_d = drop | (overflow_q & ~overflow_clr);
    end

    // Packer state registers with synchronous active-low reset.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            lane_q     <= '0;
            partial_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            partial_q  <= partial_d;
            overflow_q <= overflow_d;
        end
    end

    wb_daq_sync_fifo #(
        .dw    (dw),
        .depth (fifo_depth)
    ) u_fifo (
        .clk_i       (wb_clk),
        .rst_ni      (wb_rst),
        .push_i      (push_req),
        .push_data_i (push_word),
        .pop_i       (word_ack),
        .head_o      (data_out),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fill_level)
    );

    // Request and flag outputs are direct functions of registered state.
    always_comb begin
        start_sram = ~fifo_empty;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_wb_daq_sample_packer.sv
// Self-checking bench for wb_daq_sample_packer with a queue-based scoreboard.
module tb_wb_daq_sample_packer;

    localparam int unsigned Depth = 8;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        enable;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic        word_ack;
    logic [31:0] data_out;
    logic        start_sram;
    logic [3:0]  fill_level;
    logic        overflow;
    logic        overflow_clr;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Scoreboard state: expected FIFO contents and packer model.
    logic [31:0] exp_q[$];
    int unsigned m_lane = 0;
    logic [31:0] m_partial = '0;
    logic        m_ovf = 1'b0;

    wb_daq_sample_packer #(
        .dw         (32),
        .adc_dw     (8),
        .fifo_depth (Depth)
    ) dut (
        .wb_clk       (wb_clk),
        .wb_rst       (wb_rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .word_ack     (word_ack),
        .data_out     (data_out),
        .start_sram   (start_sram),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_fill"}, 32'(fill_level), 32'(exp_q.size()));
        check({tag, "_start"}, 32'(start_sram), 32'(exp_q.size() != 0));
        check({tag, "_head"}, data_out, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // One clock of stimulus; the model is advanced from pre-edge state, then outputs are
    // compared 1 time unit after the edge.
    task automatic cycle(input string tag, input logic en, input logic sv, input logic [7:0] sd,
                         input logic ack, input logic clr);
        logic        do_pop;
        logic        do_push;
        logic [31:0] word;
        enable       = en;
        sample_valid = sv;
        sample_data  = sd;
        word_ack     = ack;
        overflow_clr = clr;
        do_pop  = ack && (exp_q.size() != 0);
        do_push = 1'b0;
        word    = '0;
        if (en && sv) begin
            m_partial[m_lane*8 +: 8] = sd;
            if (m_lane == 3) begin
                do_push   = 1'b1;
                word      = m_partial;
                m_partial = '0;
                m_lane    = 0;
            end else begin
                m_lane++;
            end
        end else if (!en && m_lane != 0) begin
            do_push   = 1'b1;
            word      = m_partial;
            m_partial = '0;
            m_lane    = 0;
        end
        if (do_pop) begin
            void'(exp_q.pop_front());
        end
        if (do_push) begin
            if (exp_q.size() < Depth) begin
                exp_q.push_back(word);
                if (clr) m_ovf = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        @(posedge wb_clk);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        wb_rst       = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        word_ack     = 1'b0;
        overflow_clr = 1'b0;
        exp_q.delete();
        m_lane    = 0;
        m_partial = '0;
        m_ovf     = 1'b0;
        @(posedge wb_clk);
        #1;
        check_state(tag);
        wb_rst = 1'b1;
    endtask

    task automatic feed(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cycle(tag, 1'b1, 1'b1, 8'($urandom_range(255)), 1'b0, 1'b0);
        end
    endtask

    task automatic drain(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cycle(tag, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset("rst0");
        do_reset("rst1");

        // Basic packing and latency.
        cycle("t1_s0", 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        cycle("t1_s1", 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        cycle("t1_s2", 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        cycle("t1_s3", 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        check("t1_word", data_out, 32'h44332211);
        check("t1_fill1", 32'(fill_level), 32'd1);
        cycle("t1_ack", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_start0", 32'(start_sram), 32'd0);

        // Ack while empty must not underflow.
        cycle("empty_ack", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Flush of a partial word on disable.
        cycle("t2_s0", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        cycle("t2_s1", 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
        cycle("t2_dis", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_word", data_out, 32'h0000BBAA);
        cycle("t2_ign", 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
        check("t2_fill1", 32'(fill_level), 32'd1);
        cycle("t2_ack", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Overflow: 9 words into an 8-deep FIFO.
        feed("t3_feed", 36);
        check("t3_fill8", 32'(fill_level), 32'd8);
        check("t3_ovf", 32'(overflow), 32'd1);
        drain("t3_drain", 8);
        cycle("t3_clr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Word completion with simultaneous ack while full.
        feed("t4_fill", 35);
        cycle("t4_pp", 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
        check("t4_fill8", 32'(fill_level), 32'd8);
        check("t4_ovf0", 32'(overflow), 32'd0);
        drain("t4_drain", 8);

        // Set wins over clear in the same cycle.
        feed("t5_fill", 35);
        cycle("t5_setclr", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
        check("t5_ovf1", 32'(overflow), 32'd1);
        cycle("t5_clr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_ovf0", 32'(overflow), 32'd0);
        drain("t5_drain", 8);

        // Reset mid-operation discards buffered and partial words.
        feed("t6_fill", 14);
        do_reset("t6_rst");
        check("t6_head0", data_out, 32'h0);
        cycle("t6_s0", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        cycle("t6_s1", 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        cycle("t6_s2", 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        cycle("t6_s3", 1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        check("t6_word", data_out, 32'h04030201);
        drain("t6_drain", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
